forward_scoreboard: RTL and testbench
=====================================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data width.
REQ-002 SHALL have parameter AWIDTH, default 5, register address width; 2**AWIDTH architectural registers.
REQ-003 SHALL have parameter NREAD, default 2, number of operand read ports.
REQ-004 SHALL have parameter CWIDTH, default 2, width of the per-register in-flight counter.
REQ-005 SHALL have parameter MAX_STALL, default 15, consecutive stall cycles before timeout.
REQ-006 SHALL have ports: h_clk  in  1  clock; h_rst  in  1  reset; one clock, reset synchronous and active-high.
REQ-007 SHALL have ports: h_i_rs_addr  in  NREAD*AWIDTH  decoder source addresses; h_i_rs_data  in  NREAD*DWIDTH  register-file data; h_i_rs_used  in  NREAD  port carries a real operand.
REQ-008 SHALL have ports: h_i_issue  in  1  decode instruction leaves decode this cycle; h_i_issue_we  in  1  writes rd; h_i_issue_rd  in  AWIDTH  destination.
REQ-009 SHALL have ports: h_i_alu_valid  in  1; h_i_alu_we  in  1; h_i_alu_rd  in  AWIDTH; h_i_alu_data  in  DWIDTH  (memory-stage result).
REQ-010 SHALL have ports: h_i_wb_ce  in  1; h_i_wb_we  in  1; h_i_wb_rd  in  AWIDTH; h_i_wb_data  in  DWIDTH  (writeback result).
REQ-011 SHALL have ports: h_i_flush  in  1  pipeline flush; h_o_rs_data  out  NREAD*DWIDTH  resolved operands; h_o_stall  out  1; h_o_timeout  out  1  sticky; h_o_sb_err  out  1  sticky counter overflow/underflow.

Function
REQ-012 SHALL keep a CWIDTH-bit pending counter per register; register 0 is never tracked.
REQ-013 SHALL increment pending[rd] at h_clk when h_i_issue && h_i_issue_we && rd!=0 && !h_i_stall-free condition violated, i.e. only when h_o_stall==0.
REQ-014 SHALL decrement pending[rd] when h_i_wb_ce && h_i_wb_we && wb_rd!=0; simultaneous increment and decrement of the same register leaves it unchanged.
REQ-015 SHALL saturate: increment at all-ones or decrement at zero leaves counter unchanged and sets h_o_sb_err.
REQ-016 Per port p, combinationally: ALU hit = alu_we && alu_rd==addr; WB hit = wb_ce && wb_we && wb_rd==addr.
REQ-017 ALU hit with alu_valid SHALL forward h_i_alu_data; ALU hit without alu_valid SHALL stall.
REQ-018 Without ALU hit, if pending[addr] minus (WB hit ? 1 : 0) is nonzero, port SHALL stall (older producer not yet at ALU output).
REQ-019 Otherwise WB hit SHALL forward h_i_wb_data, else h_i_rs_data.
REQ-020 addr==0 SHALL output zero and never stall; h_i_rs_used==0 SHALL never stall (data still resolved).
REQ-021 h_o_stall SHALL be the OR of all port stalls, zero-latency combinational.
REQ-022 SHALL run watchdog FSM IDLE -> STALL (h_o_stall=1) -> TIMEOUT; counter increments each stalled cycle, returns to IDLE and clears when h_o_stall=0.
REQ-023 On reaching MAX_STALL consecutive stalled cycles SHALL enter TIMEOUT and set h_o_timeout; TIMEOUT exits only on flush or reset.
REQ-024 h_i_flush SHALL at next edge clear all pending counters, watchdog, and h_o_timeout; issue and writeback in the same cycle are ignored; h_o_sb_err is not cleared.

Reset
REQ-025 h_rst at h_clk edge SHALL zero all pending counters, FSM to IDLE, counter 0, h_o_timeout=0, h_o_sb_err=0; reset dominates flush and issue.
REQ-026 During and after reset with all pending zero, h_o_stall SHALL be 0 unless REQ-017 stall holds.

Structure
REQ-027 Shared package SHALL hold default DWIDTH/AWIDTH/NREAD/CWIDTH/MAX_STALL and the FSM state encoding (IDLE, STALL, TIMEOUT).
REQ-028 SHALL instantiate NREAD copies of sub-module forward_port (hit compare, priority mux, per-port stall); scoreboard and FSM stay in top.

Verification
REQ-029 Issue x5 write, ALU valid rd=5 data=0xAA, read rs1=5 -> out 0xAA, stall 0.
REQ-030 Issue load x7, next cycle ALU rd=7 valid=0, read rs2=7 -> stall=1; following cycle valid=1 data=0x1234 -> out 0x1234, stall 0.
REQ-031 Two issues to x3 in flight, WB x3 data=1 with nothing at ALU -> stall=1 (pending 2-1=1); after second WB data=2 -> pending 0, regfile data used.
REQ-032 Read rs1=0 while ALU writes rd=0 data=0xFF -> out 0, stall 0.
REQ-033 Hold ALU hit with valid=0 for 15 cycles -> h_o_timeout=1 at cycle 15; h_i_flush -> timeout 0, pending all 0.
REQ-034 Issue x9 four times with CWIDTH=2 and no WB -> pending saturates at 3, h_o_sb_err=1; h_rst clears it.

Source files
------------

// File: rtl/forward_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : forward_scoreboard_pkg
// Purpose : Shared defaults and watchdog state encoding for the operand
//           forwarding scoreboard and its per-port forwarding mux.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package forward_scoreboard_pkg;

  localparam int c_DWIDTH    = 32;  // data width
  localparam int c_AWIDTH    = 5;   // register address width
  localparam int c_NREAD     = 2;   // operand read ports
  localparam int c_CWIDTH    = 2;   // per-register in-flight counter width
  localparam int c_MAX_STALL = 15;  // consecutive stalled cycles before timeout

  // Stall watchdog states
  typedef enum logic [1:0] {
    WD_IDLE    = 2'd0,
    WD_STALL   = 2'd1,
    WD_TIMEOUT = 2'd2
  } wd_state_e;

endpackage
`default_nettype wire

// File: rtl/forward_port.sv
`default_nettype none
// ============================================================================
// Module  : forward_port
// Purpose : One operand read port: compares the source address against the
//           memory-stage and writeback producers, selects the freshest value
//           and decides whether the operand is not yet available.
// Ports   : i_addr/i_rs_data/i_used  - source address, regfile data, operand used
//           i_pending                - in-flight writer count for i_addr
//           i_alu_*                  - memory-stage producer
//           i_wb_*                   - writeback producer
//           o_data/o_stall           - resolved operand, port stall
// Revision: 1.0 - initial release
// ============================================================================
module forward_port
  import forward_scoreboard_pkg::*;
#(
  parameter int DWIDTH = c_DWIDTH,
  parameter int AWIDTH = c_AWIDTH,
  parameter int CWIDTH = c_CWIDTH
) (
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [DWIDTH-1:0] i_rs_data,
  input  logic              i_used,
  input  logic [CWIDTH-1:0] i_pending,
  input  logic              i_alu_valid,
  input  logic              i_alu_we,
  input  logic [AWIDTH-1:0] i_alu_rd,
  input  logic [DWIDTH-1:0] i_alu_data,
  input  logic              i_wb_ce,
  input  logic              i_wb_we,
  input  logic [AWIDTH-1:0] i_wb_rd,
  input  logic [DWIDTH-1:0] i_wb_data,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_stall
);

  logic w_alu_hit;
  logic w_wb_hit;
  logic w_older_pending;

  assign w_alu_hit = i_alu_we && (i_alu_rd == i_addr);
  assign w_wb_hit  = i_wb_ce && i_wb_we && (i_wb_rd == i_addr);
  // A writer still in flight beyond the one retiring now has not reached the
  // ALU output yet. Saturating compare: a stray writeback at count 0 never
  // manufactures a stall.
  assign w_older_pending = (i_pending > CWIDTH'(w_wb_hit));

  always_comb begin
    o_data  = i_rs_data;
    o_stall = 1'b0;
    if (i_addr == '0) begin
      o_data = '0;
    end else if (w_alu_hit) begin
      // The youngest producer wins even when its result is not ready yet.
      o_data  = i_alu_data;
      o_stall = i_used && !i_alu_valid;
    end else begin
      if (w_wb_hit) begin
        o_data = i_wb_data;
      end
      o_stall = i_used && w_older_pending;
    end
  end

endmodule
`default_nettype wire

// File: rtl/forward_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : forward_scoreboard
// Purpose : Tracks in-flight register writers, resolves NREAD operands through
//           forward_port instances, raises a combinational stall and runs a
//           stall watchdog with sticky timeout and counter-error flags.
// Ports   : h_clk/h_rst                      - clock, sync active-high reset
//           h_i_rs_addr/_data/_used          - operand read ports
//           h_i_issue/_we/_rd                - instruction leaving decode
//           h_i_alu_valid/_we/_rd/_data      - memory-stage result
//           h_i_wb_ce/_we/_rd/_data          - writeback result
//           h_i_flush                        - pipeline flush
//           h_o_rs_data/h_o_stall            - resolved operands, stall
//           h_o_timeout/h_o_sb_err           - sticky status flags
// Revision: 1.0 - initial release
// ============================================================================
module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int DWIDTH    = c_DWIDTH,
  parameter int AWIDTH    = c_AWIDTH,
  parameter int NREAD     = c_NREAD,
  parameter int CWIDTH    = c_CWIDTH,
  parameter int MAX_STALL = c_MAX_STALL
) (
  input  logic                    h_clk,
  input  logic                    h_rst,
  input  logic [NREAD*AWIDTH-1:0] h_i_rs_addr,
  input  logic [NREAD*DWIDTH-1:0] h_i_rs_data,
  input  logic [NREAD-1:0]        h_i_rs_used,
  input  logic                    h_i_issue,
  input  logic                    h_i_issue_we,
  input  logic [AWIDTH-1:0]       h_i_issue_rd,
  input  logic                    h_i_alu_valid,
  input  logic                    h_i_alu_we,
  input  logic [AWIDTH-1:0]       h_i_alu_rd,
  input  logic [DWIDTH-1:0]       h_i_alu_data,
  input  logic                    h_i_wb_ce,
  input  logic                    h_i_wb_we,
  input  logic [AWIDTH-1:0]       h_i_wb_rd,
  input  logic [DWIDTH-1:0]       h_i_wb_data,
  input  logic                    h_i_flush,
  output logic [NREAD*DWIDTH-1:0] h_o_rs_data,
  output logic                    h_o_stall,
  output logic                    h_o_timeout,
  output logic                    h_o_sb_err
);

  localparam int                c_NREGS  = 2 ** AWIDTH;
  localparam int                c_SWIDTH = $clog2(MAX_STALL + 1);
  localparam logic [c_SWIDTH-1:0] c_LAST = c_SWIDTH'(MAX_STALL - 1);

  logic [CWIDTH-1:0]   pending_q [c_NREGS];
  logic [CWIDTH-1:0]   pending_d [c_NREGS];
  logic                sb_err_q, sb_err_d;
  logic                timeout_q, timeout_d;
  wd_state_e           state_q, state_d;
  logic [c_SWIDTH-1:0] cnt_q, cnt_d;

  logic [NREAD-1:0]    w_port_stall;
  logic                w_inc;
  logic                w_dec;

  // --------------------------------------------------------------------------
  // Operand ports
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < NREAD; p++) begin : g_port
    forward_port #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH),
      .CWIDTH (CWIDTH)
    ) u_port (
      .i_addr      (h_i_rs_addr[p*AWIDTH +: AWIDTH]),
      .i_rs_data   (h_i_rs_data[p*DWIDTH +: DWIDTH]),
      .i_used      (h_i_rs_used[p]),
      .i_pending   (pending_q[h_i_rs_addr[p*AWIDTH +: AWIDTH]]),
      .i_alu_valid (h_i_alu_valid),
      .i_alu_we    (h_i_alu_we),
      .i_alu_rd    (h_i_alu_rd),
      .i_alu_data  (h_i_alu_data),
      .i_wb_ce     (h_i_wb_ce),
      .i_wb_we     (h_i_wb_we),
      .i_wb_rd     (h_i_wb_rd),
      .i_wb_data   (h_i_wb_data),
      .o_data      (h_o_rs_data[p*DWIDTH +: DWIDTH]),
      .o_stall     (w_port_stall[p])
    );
  end

  assign h_o_stall = |w_port_stall;

  // --------------------------------------------------------------------------
  // Pending-writer counters. An issue only counts once it actually leaves
  // decode, i.e. when nothing stalls it.
  // --------------------------------------------------------------------------
  assign w_inc = h_i_issue && h_i_issue_we && (h_i_issue_rd != '0) && !h_o_stall && !h_i_flush;
  assign w_dec = h_i_wb_ce && h_i_wb_we && (h_i_wb_rd != '0) && !h_i_flush;

  always_comb begin
    pending_d = pending_q;
    sb_err_d  = sb_err_q;
    if (h_i_flush) begin
      for (int i = 0; i < c_NREGS; i++) begin
        pending_d[i] = '0;
      end
    end else if (!(w_inc && w_dec && (h_i_issue_rd == h_i_wb_rd))) begin
      if (w_inc) begin
        if (pending_q[h_i_issue_rd] == {CWIDTH{1'b1}}) begin
          sb_err_d = 1'b1;
        end else begin
          pending_d[h_i_issue_rd] = pending_q[h_i_issue_rd] + CWIDTH'(1);
        end
      end
      if (w_dec) begin
        if (pending_q[h_i_wb_rd] == '0) begin
          sb_err_d = 1'b1;
        end else begin
          pending_d[h_i_wb_rd] = pending_q[h_i_wb_rd] - CWIDTH'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stall watchdog: counts consecutive stalled cycles; TIMEOUT is sticky
  // until flush or reset.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (h_i_flush) begin
      state_d   = WD_IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        WD_IDLE, WD_STALL: begin
          if (h_o_stall) begin
            cnt_d = cnt_q + c_SWIDTH'(1);
            if (cnt_q >= c_LAST) begin
              state_d   = WD_TIMEOUT;
              timeout_d = 1'b1;
            end else begin
              state_d = WD_STALL;
            end
          end else begin
            state_d = WD_IDLE;
            cnt_d   = '0;
          end
        end
        WD_TIMEOUT: begin
          state_d = WD_TIMEOUT;
        end
        default: begin
          state_d = WD_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      for (int i = 0; i < c_NREGS; i++) begin
        pending_q[i] <= '0;
      end
      sb_err_q  <= 1'b0;
      timeout_q <= 1'b0;
      state_q   <= WD_IDLE;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
      timeout_q <= timeout_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  assign h_o_timeout = timeout_q;
  assign h_o_sb_err  = sb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_forward_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : tb_forward_scoreboard
// Purpose : Self-checking bench for forward_scoreboard: directed table,
//           hand-written multi-cycle sequences and random stimulus compared
//           against a behavioural model.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_forward_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int CW = 2;
  localparam int MS = 15;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [31:0] D0 = 32'hD0D0_0000;
  localparam logic [31:0] D1 = 32'hD1D1_0000;

  logic           h_clk = 1'b0;
  logic           h_rst;
  logic [NR*AW-1:0] h_i_rs_addr;
  logic [NR*DW-1:0] h_i_rs_data;
  logic [NR-1:0]  h_i_rs_used;
  logic           h_i_issue, h_i_issue_we;
  logic [AW-1:0]  h_i_issue_rd;
  logic           h_i_alu_valid, h_i_alu_we;
  logic [AW-1:0]  h_i_alu_rd;
  logic [DW-1:0]  h_i_alu_data;
  logic           h_i_wb_ce, h_i_wb_we;
  logic [AW-1:0]  h_i_wb_rd;
  logic [DW-1:0]  h_i_wb_data;
  logic           h_i_flush;
  logic [NR*DW-1:0] h_o_rs_data;
  logic           h_o_stall, h_o_timeout, h_o_sb_err;

  always #5 h_clk = ~h_clk;

  forward_scoreboard dut (
    .h_clk(h_clk), .h_rst(h_rst),
    .h_i_rs_addr(h_i_rs_addr), .h_i_rs_data(h_i_rs_data), .h_i_rs_used(h_i_rs_used),
    .h_i_issue(h_i_issue), .h_i_issue_we(h_i_issue_we), .h_i_issue_rd(h_i_issue_rd),
    .h_i_alu_valid(h_i_alu_valid), .h_i_alu_we(h_i_alu_we), .h_i_alu_rd(h_i_alu_rd),
    .h_i_alu_data(h_i_alu_data),
    .h_i_wb_ce(h_i_wb_ce), .h_i_wb_we(h_i_wb_we), .h_i_wb_rd(h_i_wb_rd), .h_i_wb_data(h_i_wb_data),
    .h_i_flush(h_i_flush),
    .h_o_rs_data(h_o_rs_data), .h_o_stall(h_o_stall), .h_o_timeout(h_o_timeout),
    .h_o_sb_err(h_o_sb_err)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: counts of outstanding writers, a stall-run length and
  // two sticky flags.
  // --------------------------------------------------------------------------
  int m_pend [32];
  bit m_err, m_to;
  int m_run;

  function automatic void m_port(input int p, output logic [31:0] d, output bit st);
    int addr, eff;
    bit alu_hit, wb_hit, used;
    addr    = int'(h_i_rs_addr[p*AW +: AW]);
    used    = h_i_rs_used[p];
    alu_hit = h_i_alu_we && (int'(h_i_alu_rd) == addr);
    wb_hit  = h_i_wb_ce && h_i_wb_we && (int'(h_i_wb_rd) == addr);
    d  = h_i_rs_data[p*DW +: DW];
    st = 1'b0;
    if (addr == 0) begin
      d = '0;
    end else if (alu_hit) begin
      d  = h_i_alu_data;
      st = used && !h_i_alu_valid;
    end else begin
      eff = m_pend[addr] - (wb_hit ? 1 : 0);
      if (wb_hit) d = h_i_wb_data;
      st = used && (eff > 0);
    end
  endfunction

  function automatic bit m_stall();
    logic [31:0] d;
    bit st, any;
    any = 1'b0;
    for (int p = 0; p < NR; p++) begin
      m_port(p, d, st);
      any = any | st;
    end
    return any;
  endfunction

  task automatic m_edge();
    bit st, inc, dec;
    int rd, wrd;
    st  = m_stall();
    rd  = int'(h_i_issue_rd);
    wrd = int'(h_i_wb_rd);
    if (h_rst) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_err = 0; m_to = 0; m_run = 0;
    end else if (h_i_flush) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_to = 0; m_run = 0;
    end else begin
      inc = h_i_issue && h_i_issue_we && rd != 0 && !st;
      dec = h_i_wb_ce && h_i_wb_we && wrd != 0;
      if (!(inc && dec && rd == wrd)) begin
        if (inc) begin
          if (m_pend[rd] == CMAX) m_err = 1; else m_pend[rd]++;
        end
        if (dec) begin
          if (m_pend[wrd] == 0) m_err = 1; else m_pend[wrd]--;
        end
      end
      if (!m_to) begin
        if (st) begin
          m_run++;
          if (m_run >= MS) m_to = 1;
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  task automatic m_check(input int n);
    logic [31:0] d;
    bit st;
    for (int p = 0; p < NR; p++) begin
      m_port(p, d, st);
      chk($sformatf("rnd%0d d%0d", n, p), h_o_rs_data[p*DW +: DW], d);
    end
    chk($sformatf("rnd%0d stall", n), 32'(h_o_stall), 32'(m_stall()));
    chk($sformatf("rnd%0d timeout", n), 32'(h_o_timeout), 32'(m_to));
    chk($sformatf("rnd%0d sb_err", n), 32'(h_o_sb_err), 32'(m_err));
  endtask

  // Advance one clock: model sees the same pre-edge state and inputs as DUT.
  task automatic tick();
    m_edge();
    @(posedge h_clk);
    #1;
  endtask

  task automatic clear_in();
    h_rst = 0; h_i_flush = 0;
    h_i_issue = 0; h_i_issue_we = 0; h_i_issue_rd = '0;
    h_i_alu_valid = 0; h_i_alu_we = 0; h_i_alu_rd = '0; h_i_alu_data = '0;
    h_i_wb_ce = 0; h_i_wb_we = 0; h_i_wb_rd = '0; h_i_wb_data = '0;
    h_i_rs_addr = '0; h_i_rs_used = '0;
    h_i_rs_data = {D1, D0};
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table: one row per cycle, outputs checked before the edge
  // --------------------------------------------------------------------------
  typedef struct {
    bit rst, flush, issue;
    logic [4:0] ird;
    bit alu_we, alu_v;
    logic [4:0] ard;
    logic [31:0] adat;
    bit wb;
    logic [4:0] wrd;
    logic [31:0] wdat;
    logic [4:0] a0, a1;
    logic [1:0] used;
    logic [31:0] e0, e1;
    bit est;
  } vec_t;

  function automatic vec_t V(bit rst, bit flush, bit issue, logic [4:0] ird,
                             bit alu_we, bit alu_v, logic [4:0] ard, logic [31:0] adat,
                             bit wb, logic [4:0] wrd, logic [31:0] wdat,
                             logic [4:0] a0, logic [4:0] a1, logic [1:0] used,
                             logic [31:0] e0, logic [31:0] e1, bit est);
    vec_t v;
    v.rst = rst; v.flush = flush; v.issue = issue; v.ird = ird;
    v.alu_we = alu_we; v.alu_v = alu_v; v.ard = ard; v.adat = adat;
    v.wb = wb; v.wrd = wrd; v.wdat = wdat;
    v.a0 = a0; v.a1 = a1; v.used = used;
    v.e0 = e0; v.e1 = e1; v.est = est;
    return v;
  endfunction

  vec_t tv [17];

  initial begin
    // reset state and idle
    tv[0]  = V(1,0, 0,0,  0,0,0,0,          0,0,0,        0,0,2'b00,  0,0,0);
    // x5 issued, ALU forwards 0xAA, then writeback retires it
    tv[1]  = V(0,0, 1,5,  0,0,0,0,          0,0,0,        0,0,2'b00,  0,0,0);
    tv[2]  = V(0,0, 0,0,  1,1,5,32'hAA,     0,0,0,        5,0,2'b01,  32'hAA,0,0);
    tv[3]  = V(0,0, 0,0,  0,0,0,0,          1,5,32'h55,   5,0,2'b01,  32'h55,0,0);
    // load x7: ALU not valid stalls, then forwards 0x1234
    tv[4]  = V(0,0, 1,7,  0,0,0,0,          0,0,0,        0,0,2'b00,  0,0,0);
    tv[5]  = V(0,0, 0,0,  1,0,7,0,          0,0,0,        0,7,2'b10,  0,0,1);
    tv[6]  = V(0,0, 0,0,  1,1,7,32'h1234,   0,0,0,        0,7,2'b10,  0,32'h1234,0);
    tv[7]  = V(0,0, 0,0,  0,0,0,0,          1,7,32'h1234, 0,0,2'b00,  0,0,0);
    // two writers to x3: first WB still stalls, second forwards, then regfile
    tv[8]  = V(0,0, 1,3,  0,0,0,0,          0,0,0,        0,0,2'b00,  0,0,0);
    tv[9]  = V(0,0, 1,3,  0,0,0,0,          0,0,0,        0,0,2'b00,  0,0,0);
    tv[10] = V(0,0, 0,0,  0,0,0,0,          1,3,32'h1,    3,0,2'b01,  32'h1,0,1);
    tv[11] = V(0,0, 0,0,  0,0,0,0,          1,3,32'h2,    3,0,2'b01,  32'h2,0,0);
    tv[12] = V(0,0, 0,0,  0,0,0,0,          0,0,0,        3,0,2'b01,  D0,0,0);
    // x0 never forwards and never stalls
    tv[13] = V(0,0, 0,0,  1,1,0,32'hFF,     0,0,0,        0,0,2'b11,  0,0,0);
    // unused operand on a pending register never stalls
    tv[14] = V(0,0, 1,11, 0,0,0,0,          0,0,0,        0,0,2'b00,  0,0,0);
    tv[15] = V(0,0, 0,0,  0,0,0,0,          0,0,0,        11,11,2'b00, D0,D1,0);
    tv[16] = V(0,0, 0,0,  0,0,0,0,          1,11,32'h7,   0,0,2'b00,  0,0,0);
  end

  initial begin
    foreach (m_pend[i]) m_pend[i] = 0;
    m_err = 0; m_to = 0; m_run = 0;
    clear_in();
    h_rst = 1;
    @(posedge h_clk); #1;
    tick();
    tick();

    // ---------------- table ----------------
    for (int i = 0; i < 17; i++) begin
      clear_in();
      h_rst = tv[i].rst; h_i_flush = tv[i].flush;
      h_i_issue = tv[i].issue; h_i_issue_we = tv[i].issue; h_i_issue_rd = tv[i].ird;
      h_i_alu_we = tv[i].alu_we; h_i_alu_valid = tv[i].alu_v;
      h_i_alu_rd = tv[i].ard; h_i_alu_data = tv[i].adat;
      h_i_wb_ce = tv[i].wb; h_i_wb_we = tv[i].wb; h_i_wb_rd = tv[i].wrd; h_i_wb_data = tv[i].wdat;
      h_i_rs_addr = {tv[i].a1, tv[i].a0}; h_i_rs_used = tv[i].used;
      @(negedge h_clk);
      chk($sformatf("row%0d d0", i), h_o_rs_data[DW-1:0], tv[i].e0);
      chk($sformatf("row%0d d1", i), h_o_rs_data[2*DW-1:DW], tv[i].e1);
      chk($sformatf("row%0d stall", i), 32'(h_o_stall), 32'(tv[i].est));
      chk($sformatf("row%0d timeout", i), 32'(h_o_timeout), 32'd0);
      chk($sformatf("row%0d sb_err", i), 32'(h_o_sb_err), 32'd0);
      tick();
    end

    // ---------------- watchdog timeout and flush ----------------
    clear_in();
    h_i_issue = 1; h_i_issue_we = 1; h_i_issue_rd = 5'd10;
    tick();
    for (int k = 0; k < 16; k++) begin
      clear_in();
      h_i_alu_we = 1; h_i_alu_valid = 0; h_i_alu_rd = 5'd6;
      h_i_rs_addr = {5'd0, 5'd6}; h_i_rs_used = 2'b01;
      @(negedge h_clk);
      chk($sformatf("wd%0d stall", k), 32'(h_o_stall), 32'd1);
      chk($sformatf("wd%0d timeout", k), 32'(h_o_timeout), (k >= MS) ? 32'd1 : 32'd0);
      tick();
    end
    clear_in();
    h_i_flush = 1; h_i_issue = 1; h_i_issue_we = 1; h_i_issue_rd = 5'd9;
    @(negedge h_clk);
    chk("flush timeout held", 32'(h_o_timeout), 32'd1);
    tick();
    clear_in();
    h_i_rs_addr = {5'd9, 5'd10}; h_i_rs_used = 2'b11;
    @(negedge h_clk);
    chk("post-flush stall", 32'(h_o_stall), 32'd0);
    chk("post-flush timeout", 32'(h_o_timeout), 32'd0);
    chk("post-flush d0", h_o_rs_data[DW-1:0], D0);
    tick();

    // ---------------- counter saturation and reset ----------------
    for (int i = 0; i < 4; i++) begin
      clear_in();
      h_i_issue = 1; h_i_issue_we = 1; h_i_issue_rd = 5'd9;
      @(negedge h_clk);
      chk($sformatf("sat%0d sb_err", i), 32'(h_o_sb_err), 32'd0);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      clear_in();
      h_i_wb_ce = 1; h_i_wb_we = 1; h_i_wb_rd = 5'd9; h_i_wb_data = 32'(j + 100);
      h_i_rs_addr = {5'd0, 5'd9}; h_i_rs_used = 2'b01;
      @(negedge h_clk);
      chk($sformatf("drain%0d sb_err", j), 32'(h_o_sb_err), 32'd1);
      chk($sformatf("drain%0d stall", j), 32'(h_o_stall), (j < 2) ? 32'd1 : 32'd0);
      chk($sformatf("drain%0d d0", j), h_o_rs_data[DW-1:0], 32'(j + 100));
      tick();
    end
    clear_in();
    h_rst = 1; h_i_flush = 1; h_i_issue = 1; h_i_issue_we = 1; h_i_issue_rd = 5'd4;
    tick();
    clear_in();
    h_i_rs_addr = {5'd0, 5'd4}; h_i_rs_used = 2'b01;
    @(negedge h_clk);
    chk("reset sb_err", 32'(h_o_sb_err), 32'd0);
    chk("reset stall", 32'(h_o_stall), 32'd0);
    tick();

    // ---------------- random vs model ----------------
    for (int n = 0; n < 3000; n++) begin
      clear_in();
      h_rst         = ($urandom_range(0, 199) == 0);
      h_i_flush     = ($urandom_range(0, 31) == 0);
      h_i_issue     = $urandom_range(0, 1) == 1;
      h_i_issue_we  = $urandom_range(0, 3) != 0;
      h_i_issue_rd  = AW'($urandom_range(0, 3));
      h_i_alu_valid = $urandom_range(0, 1) == 1;
      h_i_alu_we    = $urandom_range(0, 1) == 1;
      h_i_alu_rd    = AW'($urandom_range(0, 3));
      h_i_alu_data  = $urandom;
      h_i_wb_ce     = $urandom_range(0, 2) == 0;
      h_i_wb_we     = $urandom_range(0, 3) != 0;
      h_i_wb_rd     = AW'($urandom_range(0, 3));
      h_i_wb_data   = $urandom;
      h_i_rs_addr   = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      h_i_rs_used   = NR'($urandom_range(0, 3));
      h_i_rs_data   = {32'($urandom), 32'($urandom)};
      @(negedge h_clk);
      m_check(n);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
